// File: rtl/ps2_keyboard_tx_if.sv
// Byte handshake into ps2_keyboard_tx: a byte moves when tx_valid && tx_ready at a clk posedge.
interface ps2_keyboard_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ps2_keyboard_tx.sv
// PS/2 device-side transmitter: 11-bit frames (start, 8 data LSB-first, odd parity, stop); input FIFO with PS2_TX_FIFO_EN.
// Latency: start bit on the acceptance edge (one pop cycle later with the FIFO); frame 22*CLK_DIV then GAP_CYCLES idle-high.
// Backpressure: tx_ready low through each frame and gap; with the FIFO, low only while the FIFO is full.
module ps2_keyboard_tx #(
    parameter int CLK_DIV    = 50,
    parameter int GAP_CYCLES = 200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    ps2_keyboard_tx_if.slave tx,
    output logic             ps2_clk,
    output logic             ps2_data,
    output logic             busy,
    output logic [7:0]       frames_sent
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BIT_HI = 2'd1;
    localparam logic [1:0] BIT_LO = 2'd2;
    localparam logic [1:0] GAP    = 2'd3;

    logic [1:0]       state;
    logic [9:0]       shreg;     // frame bits still to go on the line: {stop, parity, byte}
    logic [3:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             load_vld;
    logic [7:0]       load_dat;
    logic             div_end;
    logic             gap_end;

    assign div_end = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign gap_end = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign busy    = (state != IDLE);

`ifdef PS2_TX_FIFO_EN
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
    assign push        = tx.tx_valid && !fifo_full;
    assign load_vld    = (state == IDLE) && !fifo_empty;
    assign load_dat    = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign tx.tx_ready = !fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[PTR_W-1:0]] <= tx.tx_data;
                wr_ptr                      <= wr_ptr + (PTR_W+1)'(1);
            end
            if (load_vld) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end
`else
    assign load_vld    = (state == IDLE) && tx.tx_valid;
    assign load_dat    = tx.tx_data;
    assign tx.tx_ready = (state == IDLE);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            gap_cnt     <= '0;
            ps2_clk     <= 1'b1;
            ps2_data    <= 1'b1;
            frames_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_vld) begin
                        shreg    <= {1'b1, ~^load_dat, load_dat};
                        ps2_data <= 1'b0;
                        ps2_clk  <= 1'b1;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        state    <= BIT_HI;
                    end
                end
                BIT_HI: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        ps2_clk <= 1'b0;
                        state   <= BIT_LO;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                BIT_LO: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        ps2_clk <= 1'b1;
                        if (bit_cnt == 4'd10) begin
                            gap_cnt     <= '0;
                            ps2_data    <= 1'b1;
                            frames_sent <= frames_sent + 8'd1;
                            state       <= GAP;
                        end else begin
                            // Data only moves here, so it is settled well before the next falling edge.
                            ps2_data <= shreg[0];
                            shreg    <= {1'b0, shreg[9:1]};
                            bit_cnt  <= bit_cnt + 4'd1;
                            state    <= BIT_HI;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
